// File: rtl/program_loader.sv
// Boot loader: assembles a little-endian byte stream into instruction words,
// writes them to instruction memory and holds the core in reset until done.
//
// Ports:
//   CLK, Reset        clock and synchronous active-high reset
//   start             restart pulse, honoured only in DONE or ERROR
//   rx_data/rx_valid  incoming byte stream
//   rx_ready          byte accepted when rx_valid & rx_ready
//   imem_we/addr/wdata  one-cycle instruction-memory write per word
//   core_reset        holds the core in reset while high
//   load_done         image loaded, core released
//   load_error        load aborted (bad count, timeout, bad checksum)
//
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to expect a trailing
// XOR checksum byte over the payload before releasing the core.
module program_loader #(
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int IW = $clog2(TIMEOUT_CYC + 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_DONE, S_ERROR, S_CSUM
    } state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_DONE, S_ERROR
    } state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t         state;
    state_t         state_n;
    logic [1:0]     bcnt;
    logic [23:0]    wbuf;
    logic [31:0]    idx;
    logic [31:0]    nwords;
    logic [IW-1:0]  idle;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    logic        acc;
    logic        last_byte;
    logic        active;
    logic        timeout;
    logic        restart;
    logic [31:0] word;

    assign acc       = rx_valid & rx_ready;
    assign last_byte = acc && (bcnt == 2'd3);
    assign word      = {rx_data, wbuf};
    assign restart   = start && (state == S_DONE || state == S_ERROR);

    // The idle watchdog arms on the first header byte and stays armed
    // until the image completes.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign active = (state == S_DATA) || (state == S_CSUM) ||
                    (state == S_HDR && bcnt != 2'd0);
`else
    assign active = (state == S_DATA) ||
                    (state == S_HDR && bcnt != 2'd0);
`endif
    assign timeout = active && !acc && (idle == IW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK) begin
        if (Reset) state <= S_HDR;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_HDR: begin
                if (timeout) begin
                    state_n = S_ERROR;
                end else if (last_byte) begin
                    if (word == 32'd0)                  state_n = S_END;
                    else if (word > 32'(MAX_WORDS))     state_n = S_ERROR;
                    else                                state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (timeout)
                    state_n = S_ERROR;
                else if (last_byte && (idx + 32'd1 == nwords))
                    state_n = S_END;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (timeout)  state_n = S_ERROR;
                else if (acc) state_n = (rx_data == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (start) state_n = S_HDR;
            end
            default: state_n = S_HDR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            bcnt       <= 2'd0;
            wbuf       <= 24'd0;
            idx        <= 32'd0;
            nwords     <= 32'd0;
            idle       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            rx_ready   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we    <= 1'b0;
            rx_ready   <= !(state_n == S_DONE || state_n == S_ERROR);
            // Release lags DONE entry by one cycle so the last write lands first.
            load_done  <= (state == S_DONE) && (state_n == S_DONE);
            core_reset <= !((state == S_DONE) && (state_n == S_DONE));
            load_error <= (state_n == S_ERROR);
            idle       <= (acc || !active) ? '0 : idle + IW'(1);

            if (restart) begin
                bcnt <= 2'd0;
                idx  <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum <= 8'd0;
`endif
            end else if (acc && (state == S_HDR || state == S_DATA)) begin
                bcnt <= bcnt + 2'd1;
                unique case (bcnt)
                    2'd0:    wbuf[7:0]   <= rx_data;
                    2'd1:    wbuf[15:8]  <= rx_data;
                    2'd2:    wbuf[23:16] <= rx_data;
                    default: ;
                endcase
                if (state == S_HDR && bcnt == 2'd3) begin
                    nwords <= word;
                    idx    <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum   <= 8'd0;
`endif
                end
                if (state == S_DATA) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum <= csum ^ rx_data;
`endif
                    if (bcnt == 2'd3) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= idx << 2;
                        imem_wdata <= word;
                        idx        <= idx + 32'd1;
                    end
                end
            end
        end
    end

endmodule
